multi_way_dual_port_blockram: RTL and testbench

Parametrised next-generation dual-port block RAM holding NUMBER_WAYS independent ways per set. It provides one synchronous read port returning all ways of a set, and one write port with per-way enables and eviction of the overwritten element. It adds a post-reset clear state machine and a selectable read/write collision mode. It is the storage primitive for set-associative cache tag/data arrays.

---
 rtl/multi_way_dual_port_blockram_pkg.sv | 13 +
 rtl/multi_way_dual_port_blockram_way_bank.sv | 37 +++
 rtl/multi_way_dual_port_blockram.sv | 78 +++++++
 tb/tb_multi_way_dual_port_blockram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multi_way_dual_port_blockram_pkg.sv
// multi_way_dual_port_blockram_pkg: shared FSM encoding, collision-mode constants and way-select helper.
package multi_way_dual_port_blockram_pkg;
  typedef enum logic {STATE_INIT = 1'b0, STATE_READY = 1'b1} state_t;
  localparam int READ_FIRST = 0;
  localparam int WRITE_FIRST = 1;
  localparam int MAX_WAYS = 32;
  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] lowest_set_bit(input logic [MAX_WAYS-1:0] v);
    lowest_set_bit = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--)
      if (v[i]) lowest_set_bit = 5'(i);
  endfunction
endpackage

// File: rtl/multi_way_dual_port_blockram_way_bank.sv
// blockram_way_bank: storage for one way with registered read, registered evict and collision forwarding.
module blockram_way_bank
  import multi_way_dual_port_blockram_pkg::*;
#(
  parameter int W = 64,
  parameter int SETS = 64,
  parameter int AW = 6,
  parameter int WRITE_FIRST_MODE = 0
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          read_en,
  input  logic [AW-1:0] read_addr,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  logic [W-1:0]  write_data,
  input  logic          evict_en,
  output logic [W-1:0]  read_data,
  output logic [W-1:0]  evict_data
);
  logic [W-1:0] mem [SETS];
  logic read_in_range;
  logic forward;
  assign read_in_range = {1'b0, read_addr} < (AW + 1)'(SETS);
  assign forward = (WRITE_FIRST_MODE == WRITE_FIRST) && write_en && (write_addr == read_addr);
  // Storage carries no reset; the top-level clear sequence zeroes it.
  always_ff @(posedge clk_in)
    if (write_en) mem[write_addr] <= write_data;
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      read_data <= '0;
      evict_data <= '0;
    end else begin
      if (read_en) read_data <= !read_in_range ? '0 : forward ? write_data : mem[read_addr];
      if (evict_en) evict_data <= mem[write_addr];
    end
endmodule

// File: rtl/multi_way_dual_port_blockram.sv
// multi_way_dual_port_blockram: set-associative dual-port RAM with post-reset clear and selectable collision mode.
module multi_way_dual_port_blockram
  import multi_way_dual_port_blockram_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int NUMBER_WAYS = 4,
  parameter int WRITE_FIRST_MODE = 0
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  output logic                                                init_done_out,
  input  logic                                                read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    read_set_addr_in,
  output logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0]  read_way_data_out,
  output logic                                                read_valid_out,
  input  logic                                                write_en_in,
  input  logic [NUMBER_WAYS-1:0]                              write_way_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]              write_element_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]              evict_element_out,
  output logic                                                evict_valid_out
);
  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam int SEL_W = NUMBER_WAYS > 1 ? $clog2(NUMBER_WAYS) : 1;
  state_t state, next_state;
  logic [AW-1:0] clear_set;
  logic ready, read_acc, write_acc, write_in_range;
  logic [SEL_W-1:0] write_way, evict_way;
  logic [W-1:0] evict_data [NUMBER_WAYS];
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      state <= STATE_INIT;
      clear_set <= '0;
    end else begin
      state <= next_state;
      if (state == STATE_INIT) clear_set <= clear_set + 1'b1;
    end
  always_comb next_state = (state == STATE_INIT && clear_set == AW'(NUMBER_SETS - 1)) ? STATE_READY : state;
  always_comb begin
    ready = state == STATE_READY;
    init_done_out = ready;
  end
  assign write_in_range = {1'b0, write_set_addr_in} < (AW + 1)'(NUMBER_SETS);
  assign read_acc = ready && read_en_in;
  assign write_acc = ready && write_en_in && |write_way_en_in && write_in_range;
  assign write_way = SEL_W'(lowest_set_bit(MAX_WAYS'(write_way_en_in)));
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      read_valid_out <= 1'b0;
      evict_valid_out <= 1'b0;
      evict_way <= '0;
    end else begin
      read_valid_out <= read_acc;
      evict_valid_out <= write_acc;
      if (write_acc) evict_way <= write_way;
    end
  assign evict_element_out = evict_data[evict_way];
  // While clearing, every bank is driven to write zero at the clear pointer.
  for (genvar g = 0; g < NUMBER_WAYS; g++) begin : g_way
    blockram_way_bank #(
      .W(W), .SETS(NUMBER_SETS), .AW(AW), .WRITE_FIRST_MODE(WRITE_FIRST_MODE)
    ) u_bank (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .read_en(read_acc),
      .read_addr(read_set_addr_in),
      .write_en(ready ? write_acc && write_way_en_in[g] : 1'b1),
      .write_addr(ready ? write_set_addr_in : clear_set),
      .write_data(ready ? write_element_in : '0),
      .evict_en(write_acc && write_way == SEL_W'(g)),
      .read_data(read_way_data_out[g*W +: W]),
      .evict_data(evict_data[g])
    );
  end
endmodule

// File: tb/tb_multi_way_dual_port_blockram.sv
// tb_multi_way_dual_port_blockram: read-first and write-first instances driven in parallel against a set/way array model.
module tb_multi_way_dual_port_blockram;
  localparam int W = 64, SETS = 64, AW = 6, NW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ren = 1'b0, wen = 1'b0;
  logic [AW-1:0] ra = '0, wa = '0;
  logic [NW-1:0] we = '0;
  logic [W-1:0] wd = '0;
  logic done0, done1, rv0, rv1, ev0, ev1;
  logic [NW*W-1:0] rd0, rd1;
  logic [W-1:0] evd0, evd1;
  logic [W-1:0] mem [SETS][NW];
  logic [NW*W-1:0] exp_rd0, exp_rd1;
  logic [W-1:0] exp_evd;
  logic exp_rv, exp_ev;
  int init_cnt;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multi_way_dual_port_blockram #(.SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(SETS),
    .SET_PTR_WIDTH_IN_BITS(AW), .NUMBER_WAYS(NW), .WRITE_FIRST_MODE(0)) dut0 (
    .clk_in(clk), .reset_in(rst_n), .init_done_out(done0),
    .read_en_in(ren), .read_set_addr_in(ra), .read_way_data_out(rd0), .read_valid_out(rv0),
    .write_en_in(wen), .write_way_en_in(we), .write_set_addr_in(wa), .write_element_in(wd),
    .evict_element_out(evd0), .evict_valid_out(ev0));

  multi_way_dual_port_blockram #(.SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(SETS),
    .SET_PTR_WIDTH_IN_BITS(AW), .NUMBER_WAYS(NW), .WRITE_FIRST_MODE(1)) dut1 (
    .clk_in(clk), .reset_in(rst_n), .init_done_out(done1),
    .read_en_in(ren), .read_set_addr_in(ra), .read_way_data_out(rd1), .read_valid_out(rv1),
    .write_en_in(wen), .write_way_en_in(we), .write_set_addr_in(wa), .write_element_in(wd),
    .evict_element_out(evd1), .evict_valid_out(ev1));

  task automatic chk(input string tag, input logic [NW*W-1:0] got, input logic [NW*W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < NW; w++) mem[s][w] = '0;
    exp_rd0 = '0; exp_rd1 = '0; exp_evd = '0; exp_rv = 0; exp_ev = 0; init_cnt = 0;
  endtask

  task automatic check_all();
    chk("init_done0", NW*W'(done0), NW*W'(init_cnt >= SETS));
    chk("init_done1", NW*W'(done1), NW*W'(init_cnt >= SETS));
    chk("read_valid0", NW*W'(rv0), NW*W'(exp_rv));
    chk("read_valid1", NW*W'(rv1), NW*W'(exp_rv));
    chk("read_data_rf", rd0, exp_rd0);
    chk("read_data_wf", rd1, exp_rd1);
    chk("evict_valid0", NW*W'(ev0), NW*W'(exp_ev));
    chk("evict_valid1", NW*W'(ev1), NW*W'(exp_ev));
    if (exp_ev) begin
      chk("evict_data0", NW*W'(evd0), NW*W'(exp_evd));
      chk("evict_data1", NW*W'(evd1), NW*W'(exp_evd));
    end
  endtask

  // One clock: model consumes current inputs, then outputs are checked 1ns after the edge.
  task automatic tick();
    if (init_cnt >= SETS) begin
      exp_rv = ren;
      if (ren)
        for (int w = 0; w < NW; w++) begin
          exp_rd0[w*W +: W] = mem[ra][w];
          exp_rd1[w*W +: W] = (wen && we[w] && wa == ra) ? wd : mem[ra][w];
        end
      exp_ev = wen && we != 0;
      if (exp_ev) begin
        for (int w = NW - 1; w >= 0; w--) if (we[w]) exp_evd = mem[wa][w];
        for (int w = 0; w < NW; w++) if (we[w]) mem[wa][w] = wd;
      end
    end else begin
      exp_rv = 0;
      exp_ev = 0;
      init_cnt++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input int rset, input logic wr, input logic [NW-1:0] wen_ways,
                       input int wset, input logic [W-1:0] data);
    ren = r; ra = AW'(rset); wen = wr; we = wen_ways; wa = AW'(wset); wd = data;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    // Requests issued during the clear sequence must be ignored.
    for (int i = 0; i < SETS; i++)
      begin drive(1, $urandom_range(0, 63), 1, 4'hF, $urandom_range(0, 63), {$urandom, $urandom}); tick(); end
    drive(1, 63, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 4'b0100, 63, 64'hFFFFFFFF00000000); tick();
    drive(1, 63, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 4'b0010, 62, 64'h00000000FFFFFFFF); tick();
    drive(0, 0, 1, 4'b0010, 62, 64'hFFFFFFFF00000000); tick();
    chk("evict_set62", NW*W'(evd0), NW*W'(64'h00000000FFFFFFFF));
    drive(0, 0, 1, 4'b0000, 62, 64'h5555); tick();
    drive(0, 0, 1, 4'b1011, 62, 64'h77); tick();
    drive(0, 0, 1, 4'b0001, 61, 64'h1234); tick();
    drive(1, 61, 1, 4'b0001, 61, '1); tick();
    chk("collide_rf_way0", NW*W'(rd0[W-1:0]), NW*W'(64'h1234));
    chk("collide_wf_way0", NW*W'(rd1[W-1:0]), NW*W'({W{1'b1}}));
    drive(1, 61, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 4'b1000, 60, 64'h00000000FFFFFFFF); tick();
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0, 4'b1000, 60, 64'hAAAAAAAAAAAAAAAA); tick(); end
    drive(1, 60, 0, 0, 0, 0); tick();
    chk("hold_way3", NW*W'(rd0[3*W +: W]), NW*W'(64'h00000000FFFFFFFF));
    drive(1, 0, 1, 4'b1111, 0, 64'hDEAD); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 400; i++) begin
      int r_set, w_set;
      r_set = $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(56, 63);
      w_set = $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(56, 63);
      drive($urandom_range(0, 1), r_set, $urandom_range(0, 1), NW'($urandom), w_set, {$urandom, $urandom});
      tick();
    end
    drive(1, 40, 1, 4'b1111, 40, 64'hCAFE); tick();
    drive(1, 40, 0, 0, 0, 0); tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin drive(1, 40, 0, 0, 0, 0); tick(); end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < SETS; i++) begin drive(0, 0, 0, 0, 0, 0); tick(); end
    drive(1, 40, 0, 0, 0, 0); tick();
    chk("cleared_set40", rd0, '0);
    drive(0, 0, 0, 0, 0, 0); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
